// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and constant tables for the PRBS generator/checker.
//   prbs_mode_t  - polynomial select (PRBS7/15/23/31)
//   chk_state_t  - checker FSM states
//   ORDER_TBL    - LFSR order N per mode
//   TAP_TBL      - second feedback tap T per mode (fb = s[N-1] ^ s[T-1])
package prbs_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'b00,
        MODE_PRBS15 = 2'b01,
        MODE_PRBS23 = 2'b10,
        MODE_PRBS31 = 2'b11
    } prbs_mode_t;

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_HUNT   = 2'b01,
        ST_LOCKED = 2'b10
    } chk_state_t;

    // One register wide enough for the longest polynomial; shorter orders
    // use only the low N bits.
    localparam int LFSR_W = 31;

    localparam logic [4:0] ORDER_TBL [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
    localparam logic [4:0] TAP_TBL   [4] = '{5'd6, 5'd14, 5'd18, 5'd28};

endpackage

// File: rtl/prbs_lfsr_step.sv
// prbs_lfsr_step: combinational DATA_W-bit advance of a Fibonacci LFSR.
// Shared by the generator (shifts its own feedback back in) and by the
// self-synchronising checker (shifts the received bits in instead).
//   mode       - polynomial select
//   state      - current LFSR / history register
//   ext_bits   - bits to shift in when use_ext is high (MSB first)
//   use_ext    - 1: shift ext_bits in, 0: shift feedback in
//   next_state - register value after DATA_W steps
//   fb_bits    - feedback bit of every step, MSB = earliest
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  prbs_mode_t              mode,
    input  logic [LFSR_W-1:0]       state,
    input  logic [DATA_W-1:0]       ext_bits,
    input  logic                    use_ext,
    output logic [LFSR_W-1:0]       next_state,
    output logic [DATA_W-1:0]       fb_bits
);

    logic [LFSR_W-1:0] s;
    logic              fb;
    logic [4:0]        n_idx;
    logic [4:0]        t_idx;

    always_comb begin
        s       = state;
        fb      = 1'b0;
        fb_bits = '0;
        n_idx   = ORDER_TBL[mode] - 5'd1;
        t_idx   = TAP_TBL[mode] - 5'd1;
        // Bits above N shift out harmlessly; they never reach a tap.
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb         = s[n_idx] ^ s[t_idx];
            fb_bits[i] = fb;
            s          = {s[LFSR_W-2:0], (use_ext ? ext_bits[i] : fb)};
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS pattern generator plus self-synchronising checker.
// Optional feature macro: PRBS_ERR_INJECT_EN adds the inj_err port.
//   clk, rst          - clock, synchronous active-high reset
//   mode              - polynomial select (00 PRBS7 .. 11 PRBS31)
//   gen_en            - advance generator by DATA_W bits
//   gen_data/valid    - generated word (MSB earliest) and qualifier
//   chk_data/valid    - received word (MSB earliest) and qualifier
//   clr_cnt           - clear err_cnt / err_sat (wins over new errors)
//   inj_err           - (PRBS_ERR_INJECT_EN only) flip MSB of next gen word
//   locked            - checker in LOCKED
//   err_cnt / err_sat - saturating bit-error count while LOCKED, sat flag
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 gen_en,
    output logic [DATA_W-1:0]    gen_data,
    output logic                 gen_valid,
    input  logic [DATA_W-1:0]    chk_data,
    input  logic                 chk_valid,
    input  logic                 clr_cnt,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                 inj_err,
`endif
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sat
);

    localparam int POP_W = 6;
    localparam int SUM_W = ((ERR_CNT_W > POP_W) ? ERR_CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({ERR_CNT_W{1'b1}});
    localparam logic [7:0]       RUN_LAST = 8'(LOCK_CNT - 1);

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c = c + {{(POP_W-1){1'b0}}, v[i]};
        return c;
    endfunction

    prbs_mode_t        mode_cur;
    prbs_mode_t        mode_q;
    logic              mode_chg;
    logic [LFSR_W-1:0] gen_state, gen_next;
    logic [LFSR_W-1:0] hist, hist_next;
    logic [DATA_W-1:0] gen_bits, pred_bits, err_bits, inj_mask;
    logic              word_err;
    logic [POP_W-1:0]  err_pop;
    logic [SUM_W-1:0]  err_sum;
    logic [6:0]        fill_sum;
    chk_state_t        state;
    logic [5:0]        fill_cnt;
    logic [7:0]        run_cnt;

    assign mode_cur = prbs_mode_t'(mode);
    assign mode_chg = (mode_cur != mode_q);

    prbs_lfsr_step #(.DATA_W(DATA_W)) u_gen_step (
        .mode(mode_cur), .state(gen_state), .ext_bits('0), .use_ext(1'b0),
        .next_state(gen_next), .fb_bits(gen_bits)
    );

    prbs_lfsr_step #(.DATA_W(DATA_W)) u_chk_step (
        .mode(mode_cur), .state(hist), .ext_bits(chk_data), .use_ext(1'b1),
        .next_state(hist_next), .fb_bits(pred_bits)
    );

`ifdef PRBS_ERR_INJECT_EN
    always_comb begin
        inj_mask           = '0;
        inj_mask[DATA_W-1] = inj_err;
    end
`else
    assign inj_mask = '0;
`endif

    assign err_bits = pred_bits ^ chk_data;
    assign word_err = |err_bits;
    assign err_pop  = popcount(err_bits);
    assign err_sum  = SUM_W'(err_cnt) + SUM_W'(err_pop);
    assign fill_sum = {1'b0, fill_cnt} + 7'(DATA_W);

    // Generator: a mode change reloads the seed and costs one output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_state <= '1;
            gen_data  <= '0;
            gen_valid <= 1'b0;
            mode_q    <= mode_cur;
        end else begin
            mode_q <= mode_cur;
            if (mode_chg) begin
                gen_state <= '1;
                gen_valid <= 1'b0;
            end else if (gen_en) begin
                gen_state <= gen_next;
                gen_data  <= gen_bits ^ inj_mask;
                gen_valid <= 1'b1;
            end else begin
                gen_valid <= 1'b0;
            end
        end
    end

    // Checker: history always takes the received bits; run_cnt counts
    // consecutive clean words in HUNT and consecutive bad words in LOCKED.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            state    <= ST_FILL;
            fill_cnt <= '0;
            run_cnt  <= '0;
            locked   <= 1'b0;
            err_cnt  <= '0;
            err_sat  <= 1'b0;
        end else begin
            if (chk_valid) hist <= hist_next;

            if (mode_chg) begin
                state   <= ST_HUNT;
                run_cnt <= '0;
                locked  <= 1'b0;
            end else if (chk_valid) begin
                case (state)
                    ST_FILL: begin
                        if (fill_sum >= {2'b00, ORDER_TBL[mode_cur]}) begin
                            state   <= ST_HUNT;
                            run_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_sum[5:0];
                        end
                    end
                    ST_HUNT: begin
                        if (word_err) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RUN_LAST) begin
                            state   <= ST_LOCKED;
                            run_cnt <= '0;
                            locked  <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!word_err) begin
                            run_cnt <= '0;
                        end else if (run_cnt == RUN_LAST) begin
                            state   <= ST_HUNT;
                            run_cnt <= '0;
                            locked  <= 1'b0;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state   <= ST_FILL;
                        run_cnt <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end

            if (clr_cnt) begin
                err_cnt <= '0;
                err_sat <= 1'b0;
            end else if (chk_valid && !mode_chg && state == ST_LOCKED) begin
                if (err_sum >= CNT_MAX) begin
                    err_cnt <= '1;
                    err_sat <= 1'b1;
                end else begin
                    err_cnt <= err_sum[ERR_CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk (DATA_W=8,
// ERR_CNT_W=4, LOCK_CNT=4). Stimulus pushes expected generator words and
// expected checker status; a monitor pops and compares on each DUT output.
module tb_prbs_gen_chk;

    localparam int DW = 8;
    localparam int EW = 4;
    localparam int LC = 4;

    logic          clk = 1'b0;
    logic          rst, gen_en, gen_valid, chk_valid, clr_cnt, locked, err_sat;
    logic [1:0]    mode;
    logic [DW-1:0] gen_data, chk_data;
    logic [EW-1:0] err_cnt;
`ifdef PRBS_ERR_INJECT_EN
    logic          inj_err = 1'b0;
`endif

    prbs_gen_chk #(.DATA_W(DW), .ERR_CNT_W(EW), .LOCK_CNT(LC)) dut (
        .clk(clk), .rst(rst), .mode(mode), .gen_en(gen_en),
        .gen_data(gen_data), .gen_valid(gen_valid),
        .chk_data(chk_data), .chk_valid(chk_valid), .clr_cnt(clr_cnt),
`ifdef PRBS_ERR_INJECT_EN
        .inj_err(inj_err),
`endif
        .locked(locked), .err_cnt(err_cnt), .err_sat(err_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          do_lock;
        logic          lock;
        logic          do_cnt;
        logic [EW-1:0] cnt;
        logic          do_sat;
        logic          sat;
    } chk_exp_t;

    logic [DW-1:0] gen_q [$];
    chk_exp_t      chk_q [$];
    int            tests = 0;
    int            fails = 0;
    logic [30:0]   ms [2];
    int            cur_n = 7;
    int            cur_t = 6;
    logic          gen_hand = 1'b0;
    logic [DW-1:0] gen_hand_val = '0;
    logic [DW-1:0] last_gen = '0;
    logic          chk_vld_d = 1'b0;
    logic          rst_d = 1'b1;
    chk_exp_t      mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic chk_exp_t ex(input logic dl, input logic l, input logic dc,
                                    input logic [EW-1:0] c, input logic ds, input logic s);
        chk_exp_t e;
        e.do_lock = dl; e.lock = l; e.do_cnt = dc; e.cnt = c; e.do_sat = ds; e.sat = s;
        return e;
    endfunction

    // Bit-serial reference LFSR: k=0 generator stream, k=1 checker stream.
    task automatic adv(input int k, output logic [DW-1:0] w);
        logic fb;
        w = '0;
        for (int b = 0; b < DW; b++) begin
            fb    = ms[k][cur_n-1] ^ ms[k][cur_t-1];
            w     = {w[DW-2:0], fb};
            ms[k] = {ms[k][29:0], fb};
        end
    endtask

    task automatic step(input logic ge, input logic cv, input logic [DW-1:0] flip,
                        input logic clr, input chk_exp_t e);
        logic [DW-1:0] w;
        gen_en    = ge;
        chk_valid = cv;
        clr_cnt   = clr;
        chk_data  = '0;
        if (ge) begin
            adv(0, w);
            if (gen_hand) begin
                gen_q.push_back(gen_hand_val);
                gen_hand = 1'b0;
            end else begin
                gen_q.push_back(w);
            end
            last_gen = w;
        end
        if (cv) begin
            adv(1, w);
            chk_data = w ^ flip;
            chk_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gen_data"}, gen_data, 0);
        check({tag, "_gen_valid"}, gen_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_err_sat"}, err_sat, 0);
    endtask

    always @(posedge clk) begin
        chk_vld_d <= chk_valid;
        rst_d     <= rst;
    end

    always @(negedge clk) begin
        if (gen_valid) begin
            if (gen_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL gen_unexpected: gen_valid=1 data=%0h, required gen_valid=0", gen_data);
            end else begin
                check("gen_data", gen_data, gen_q.pop_front());
            end
        end
        if (chk_vld_d && !rst_d) begin
            if (chk_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL chk_unexpected: checker word without expectation");
            end else begin
                mon_e = chk_q.pop_front();
                if (mon_e.do_lock) check("locked", locked, mon_e.lock);
                if (mon_e.do_cnt)  check("err_cnt", err_cnt, mon_e.cnt);
                if (mon_e.do_sat)  check("err_sat", err_sat, mon_e.sat);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        chk_exp_t none;
        int       raw;
        int       cnt;
        logic [DW-1:0] fl;
        none = ex(0, 0, 0, 0, 0, 0);

        // Reset state
        rst = 1'b1; mode = 2'b00; gen_en = 0; chk_valid = 0; chk_data = '0; clr_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");

        // PRBS7 generator: first word 8'h02, then 1000 words of the model
        rst = 1'b0;
        ms[0] = '1; ms[1] = '1; cur_n = 7; cur_t = 6;
        gen_hand = 1'b1; gen_hand_val = 8'h02;
        for (int i = 0; i < 1000; i++) step(1, 0, '0, 0, none);
        step(0, 0, '0, 0, none);
        check("hold_gen_valid", gen_valid, 0);
        check("hold_gen_data", gen_data, last_gen);

        // Reset into PRBS31; first PRBS31 word from all-ones seed is 8'h00
        rst = 1'b1; mode = 2'b11;
        step(0, 0, '0, 0, none);
        step(0, 0, '0, 0, none);
        rst = 1'b0;
        ms[0] = '1; ms[1] = '1; cur_n = 31; cur_t = 28;
        gen_hand = 1'b1; gen_hand_val = 8'h00;

        // Loopback acquire: 4 FILL words, then LOCK_CNT clean words with gaps
        for (int k = 1; k <= 8; k++) begin
            if (k >= 5) step(0, 0, '0, 0, none);
            step(1, 1, '0, 0, ex(1, (k >= 8), 1, 0, 1, 0));
        end

        // Long clean run
        for (int i = 0; i < 10000; i++) step(1, 1, '0, 0, ex(1, 1, 1, 0, 1, 0));

        // Single flipped bit gives three errors (now, +28 and +31 bits later)
        for (int r = 0; r < 6; r++)
            step(1, 1, (r == 0) ? 8'h80 : 8'h00, 0, ex(1, 1, 1, (r < 3) ? 4'd1 : 4'd3, 1, 0));

        // clr_cnt alone, then clr_cnt coincident with an error word
        step(1, 1, '0, 1, ex(1, 1, 1, 0, 1, 0));
        for (int r = 0; r < 5; r++)
            step(1, 1, (r == 0) ? 8'h80 : 8'h00, (r == 0), ex(1, 1, 1, (r < 3) ? 4'd0 : 4'd2, 1, 0));
        step(1, 1, '0, 1, ex(1, 1, 1, 0, 1, 0));

        // Saturation: seven isolated flips (21 errors) into a 4-bit counter
        raw = 0;
        for (int r = 0; r < 60; r++) begin
            fl = '0;
            if (r % 8 == 0 && r < 56) begin fl = 8'h80; raw += 1; end
            if (r >= 3 && (r - 3) % 8 == 0 && (r - 3) < 56) raw += 2;
            cnt = (raw > 15) ? 15 : raw;
            step(1, 1, fl, 0, ex(1, 1, 1, 4'(cnt), (raw != 15), (raw > 15)));
        end
        step(1, 1, '0, 1, ex(1, 1, 1, 0, 1, 0));

        // Lock loss after LOCK_CNT consecutive bad words, then re-lock
        for (int r = 0; r < 15; r++) begin
            cnt = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 6;
            step(1, 1, (r < 4) ? 8'h80 : 8'h00, 0,
                 ex(1, (r < 3 || r >= 10), 1, 4'(cnt), 1, 0));
        end

        // Mode change to PRBS7 mid-stream
        mode = 2'b00; gen_en = 1'b1; chk_valid = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        check("modechg_locked", locked, 0);
        check("modechg_gen_valid", gen_valid, 0);
        ms[0] = '1; ms[1] = '1; cur_n = 7; cur_t = 6;
        gen_hand = 1'b1; gen_hand_val = 8'h02;
        for (int k = 1; k <= 20; k++)
            step(1, 1, '0, 0, ex((k != 4), (k >= 5), 1, 4'd6, 1, 0));

        // Reset while locked overrides a live, erroneous word
        rst = 1'b1; gen_en = 1'b1; chk_valid = 1'b1; chk_data = 8'hFF; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        check_reset("rst_locked");
        rst = 1'b0;
        ms[0] = '1;
        gen_hand = 1'b1; gen_hand_val = 8'h02;
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, none);
        step(0, 0, '0, 0, none);
        step(0, 0, '0, 0, none);

        check("gen_queue_drained", gen_q.size(), 0);
        check("chk_queue_drained", chk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bits generated and checked per cycle (legal 1..32).
REQ-002 Parameter ERR_CNT_W, default 16, SHALL set the error-counter width.
REQ-003 Parameter LOCK_CNT, default 8, SHALL set the consecutive-word count for lock acquire and lock loss (legal 1..255).
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-006 mode  input  2  SHALL select the polynomial: 00 PRBS7 x^7+x^6+1; 01 PRBS15 x^15+x^14+1; 10 PRBS23 x^23+x^18+1; 11 PRBS31 x^31+x^28+1.
REQ-007 gen_en  input  1  SHALL advance the generator by DATA_W bits when high.
REQ-008 gen_data  output  DATA_W  SHALL carry the generated word, MSB = earliest bit.
REQ-009 gen_valid  output  1  SHALL mark gen_data valid.
REQ-010 chk_data / chk_valid  input  DATA_W / 1  SHALL carry the received word, MSB first, and its qualifier.
REQ-011 clr_cnt  input  1  SHALL clear err_cnt and err_sat.
REQ-012 locked  output  1  SHALL be high in checker state LOCKED.
REQ-013 err_cnt  output  ERR_CNT_W  SHALL count bit errors while LOCKED; err_sat SHALL flag that it is saturated.

Function
REQ-014 The generator SHALL be a 31-bit LFSR using the low N bits for order N: fb = s[N-1]^s[T-1]; s <= {s[N-2:0],fb}; each fb SHALL be one output bit.
REQ-015 gen_data/gen_valid SHALL be registered, with 1-cycle latency from gen_en; with gen_en low, gen_valid SHALL be 0 and gen_data SHALL hold.
REQ-016 A change of mode, sampled every cycle, SHALL reload the generator with all ones on the next edge, suppress gen_valid for that cycle, and force the checker to HUNT.
REQ-017 The checker SHALL be self-synchronising: an N-bit history of received bits; predicted bit = h[N-1]^h[T-1]; the received bit SHALL always shift in; a mismatch SHALL be one bit error.
REQ-018 Checker FSM states SHALL be FILL, HUNT and LOCKED; FILL -> HUNT after N received bits; HUNT -> LOCKED after LOCK_CNT consecutive error-free valid words; LOCKED -> HUNT after LOCK_CNT consecutive valid words each holding >=1 error.
REQ-019 Words with chk_valid low SHALL be ignored and SHALL NOT reset the run counters.
REQ-020 In LOCKED, err_cnt SHALL add the per-word popcount of errors and saturate at all-ones, setting err_sat; HUNT/FILL words SHALL NOT count.
REQ-021 clr_cnt coincident with errors SHALL win; the count restarts from 0 on the next edge.
REQ-022 locked and err_cnt SHALL be registered, with 1-cycle latency from the chk_valid word.

Reset
REQ-023 rst SHALL set generator to all ones, history to zero, FSM to FILL, gen_data 0, gen_valid 0, locked 0, err_cnt 0, err_sat 0, and SHALL override all inputs, including mid-word.

Configuration
REQ-024 With PRBS_ERR_INJECT_EN defined, a port inj_err (input, 1) SHALL exist; inj_err high with gen_en SHALL invert the MSB of the next gen_data word only, leaving the LFSR unaffected.
REQ-025 Without PRBS_ERR_INJECT_EN, the inj_err port and its logic SHALL be absent.

Structure
REQ-026 Package prbs_pkg SHALL hold the mode enum, the checker state enum, and the order/tap constant tables.
REQ-027 Combinational sub-module prbs_lfsr_step (DATA_W-bit advance of state for a given mode) SHALL be shared by generator and checker.

Verification
REQ-028 rst, mode=00, DATA_W=8, gen_en=1 -> first gen_data = 8'h02, then matches the software model for 1000 words.
REQ-029 gen loopback into checker, mode=11 -> locked=1 within 4+LOCK_CNT+1 valid words; err_cnt stays 0 for 10^4 words.
REQ-030 Locked, one bit flipped in chk_data -> err_cnt = 3 (self-sync error tripling); locked stays 1.
REQ-031 Locked, LOCK_CNT consecutive corrupted words -> locked=0; clean data afterward -> re-lock.
REQ-032 mode change mid-stream -> gen reloads, locked drops, re-lock on the new polynomial; ERR_CNT_W=4 with 20 errors -> err_cnt=15, err_sat=1; clr_cnt -> 0.
REQ-033 rst asserted while locked -> all outputs return to reset values on the next edge.
